// File: rtl/dma_cmd_queue.sv
// Descriptor FIFO plus sequencer in front of the DMA engine: each descriptor is
// split into MAX_CHUNK-sized start/done jobs and retired with one tagged pulse.
module dma_cmd_queue #(
   parameter int ADDR_WIDTH      = 32,
   parameter int SRAM_ADDR_WIDTH = 16,
   parameter int DEPTH           = 4,
   parameter int MAX_CHUNK       = 4096,
   parameter int TAG_WIDTH       = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_cmd_valid,
   output logic                       o_cmd_ready,
   input  logic                       i_cmd_dir,
   input  logic [ADDR_WIDTH-1:0]      i_cmd_ddr_addr,
   input  logic [SRAM_ADDR_WIDTH-1:0] i_cmd_sram_addr,
   input  logic [31:0]                i_cmd_bytes,
   input  logic [TAG_WIDTH-1:0]       i_cmd_tag,
   output logic                       o_dma_start,
   output logic                       o_dma_direction,
   output logic [ADDR_WIDTH-1:0]      o_dma_ddr_addr,
   output logic [SRAM_ADDR_WIDTH-1:0] o_dma_sram_addr,
   output logic [31:0]                o_dma_byte_count,
   input  logic                       i_dma_busy,
   input  logic                       i_dma_done,
   output logic                       o_cpl_valid,
   output logic [TAG_WIDTH-1:0]       o_cpl_tag,
   output logic [$clog2(DEPTH):0]     o_queue_level,
   output logic                       o_idle
);

   localparam int            PW           = $clog2(DEPTH);
   localparam int            LW           = PW + 1;
   localparam logic [31:0]   LP_MAX_CHUNK = 32'(MAX_CHUNK);
   localparam logic [LW-1:0] LP_FULL      = LW'(DEPTH);

   typedef struct packed {
      logic                       dir;
      logic [ADDR_WIDTH-1:0]      ddr;
      logic [SRAM_ADDR_WIDTH-1:0] sram;
      logic [31:0]                bytes;
      logic [TAG_WIDTH-1:0]       tag;
   } desc_t;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_CPL} state_t;

   desc_t                      r_mem [DEPTH];
   logic [PW-1:0]              r_wr_ptr;
   logic [PW-1:0]              r_rd_ptr;
   logic [LW-1:0]              r_level;
   state_t                     r_state;
   state_t                     w_state_next;

   logic                       r_dir;
   logic [ADDR_WIDTH-1:0]      r_ddr;
   logic [SRAM_ADDR_WIDTH-1:0] r_sram;
   logic [31:0]                r_rem;
   logic [TAG_WIDTH-1:0]       r_tag;

   logic                       r_dma_dir;
   logic [ADDR_WIDTH-1:0]      r_dma_ddr;
   logic [SRAM_ADDR_WIDTH-1:0] r_dma_sram;
   logic [31:0]                r_dma_cnt;

   logic                       w_push;
   logic                       w_pop;
   desc_t                      w_head;
   logic [31:0]                w_chunk;
   logic [31:0]                w_rem_next;

   assign o_cmd_ready = (r_level != LP_FULL);
   assign w_push      = i_cmd_valid && o_cmd_ready;
   assign w_pop       = (r_state == S_IDLE) && (r_level != '0);
   assign w_head      = r_mem[r_rd_ptr];

   // NOTE: descriptor storage carries no reset; only the pointers and level
   // decide which entries are meaningful, so the array stays plain flops/RAM.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= '{dir: i_cmd_dir, ddr: i_cmd_ddr_addr, sram: i_cmd_sram_addr,
                              bytes: i_cmd_bytes, tag: i_cmd_tag};
      end
   end

   // NOTE: all clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // r_dma_cnt always holds the chunk of the job currently in flight.
   assign w_chunk    = (r_rem > LP_MAX_CHUNK) ? LP_MAX_CHUNK : r_rem;
   assign w_rem_next = r_rem - r_dma_cnt;

   // NOTE: every output of this block is given a default first, so no path
   // through the case can leave a signal unassigned and infer a latch.
   always_comb begin
      w_state_next = r_state;
      o_dma_start  = 1'b0;
      o_cpl_valid  = 1'b0;
      case (r_state)
         S_IDLE:  if (r_level != '0) w_state_next = S_LOAD;
         S_LOAD:  w_state_next = (r_rem == '0) ? S_CPL : S_ISSUE;
         S_ISSUE: begin
            if (!i_dma_busy) begin
               o_dma_start  = 1'b1;
               w_state_next = S_WAIT;
            end
         end
         S_WAIT:  if (i_dma_done) w_state_next = (w_rem_next == '0) ? S_CPL : S_LOAD;
         S_CPL: begin
            o_cpl_valid  = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dir      <= 1'b0;
         r_ddr      <= '0;
         r_sram     <= '0;
         r_rem      <= '0;
         r_tag      <= '0;
         r_dma_dir  <= 1'b0;
         r_dma_ddr  <= '0;
         r_dma_sram <= '0;
         r_dma_cnt  <= '0;
      end else begin
         if (w_pop) begin
            r_dir  <= w_head.dir;
            r_ddr  <= w_head.ddr;
            r_sram <= w_head.sram;
            r_rem  <= w_head.bytes;
            r_tag  <= w_head.tag;
         end
         if (r_state == S_LOAD && r_rem != '0) begin
            r_dma_dir  <= r_dir;
            r_dma_ddr  <= r_ddr;
            r_dma_sram <= r_sram;
            r_dma_cnt  <= w_chunk;
         end
         // Address advances wrap at the port width.
         if (r_state == S_WAIT && i_dma_done) begin
            r_rem  <= w_rem_next;
            r_ddr  <= r_ddr + ADDR_WIDTH'(r_dma_cnt);
            r_sram <= r_sram + SRAM_ADDR_WIDTH'(r_dma_cnt);
         end
      end
   end

   assign o_dma_direction  = r_dma_dir;
   assign o_dma_ddr_addr   = r_dma_ddr;
   assign o_dma_sram_addr  = r_dma_sram;
   assign o_dma_byte_count = r_dma_cnt;
   assign o_cpl_tag        = o_cpl_valid ? r_tag : '0;
   assign o_queue_level    = r_level;
   assign o_idle           = (r_state == S_IDLE) && (r_level == '0);

endmodule

// File: tb/tb_dma_cmd_queue.sv
// Self-checking bench for dma_cmd_queue: directed scenarios plus randomized
// traffic against a descriptor-to-job-list reference model and a DMA engine model.
module tb_dma_cmd_queue;

   localparam int MAXC = 4096;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        i_cmd_valid = 1'b0;
   logic        o_cmd_ready;
   logic        i_cmd_dir = 1'b0;
   logic [31:0] i_cmd_ddr_addr = '0;
   logic [15:0] i_cmd_sram_addr = '0;
   logic [31:0] i_cmd_bytes = '0;
   logic [3:0]  i_cmd_tag = '0;
   logic        o_dma_start;
   logic        o_dma_direction;
   logic [31:0] o_dma_ddr_addr;
   logic [15:0] o_dma_sram_addr;
   logic [31:0] o_dma_byte_count;
   logic        i_dma_busy = 1'b0;
   logic        i_dma_done = 1'b0;
   logic        o_cpl_valid;
   logic [3:0]  o_cpl_tag;
   logic [2:0]  o_queue_level;
   logic        o_idle;

   dma_cmd_queue dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_cmd_valid      (i_cmd_valid),
      .o_cmd_ready      (o_cmd_ready),
      .i_cmd_dir        (i_cmd_dir),
      .i_cmd_ddr_addr   (i_cmd_ddr_addr),
      .i_cmd_sram_addr  (i_cmd_sram_addr),
      .i_cmd_bytes      (i_cmd_bytes),
      .i_cmd_tag        (i_cmd_tag),
      .o_dma_start      (o_dma_start),
      .o_dma_direction  (o_dma_direction),
      .o_dma_ddr_addr   (o_dma_ddr_addr),
      .o_dma_sram_addr  (o_dma_sram_addr),
      .o_dma_byte_count (o_dma_byte_count),
      .i_dma_busy       (i_dma_busy),
      .i_dma_done       (i_dma_done),
      .o_cpl_valid      (o_cpl_valid),
      .o_cpl_tag        (o_cpl_tag),
      .o_queue_level    (o_queue_level),
      .o_idle           (o_idle)
   );

   always #5 clk = ~clk;

   // Expected event stream: every DMA job and every completion, in order.
   typedef struct {
      bit          is_cpl;
      bit          dir;
      logic [31:0] ddr;
      logic [15:0] sram;
      logic [31:0] cnt;
      logic [3:0]  tag;
   } ev_t;

   ev_t         exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          job_left = 0;
   bit          stall = 0;
   bit          force_busy = 0;
   bit          stray_done = 0;
   bit          rand_noise = 0;
   bit          accepted = 0;
   int          push_cyc = 0;
   int          start_cyc = 0;
   int          cpl_cyc = 0;
   int          done_cyc = 0;
   int          n_start = 0;
   int          n_cpl = 0;
   logic [31:0] cur_cnt = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic add_desc(input bit dir, input logic [31:0] ddr, input logic [15:0] sram,
                           input logic [31:0] bytes, input logic [3:0] tag);
      ev_t         e;
      logic [31:0] rem;
      logic [31:0] c;
      rem = bytes;
      while (rem != 0) begin
         c = (rem > 32'(MAXC)) ? 32'(MAXC) : rem;
         e = '{is_cpl: 1'b0, dir: dir, ddr: ddr, sram: sram, cnt: c, tag: tag};
         exp_q.push_back(e);
         ddr  = ddr + c;
         sram = sram + c[15:0];
         rem  = rem - c;
      end
      e = '{is_cpl: 1'b1, dir: dir, ddr: '0, sram: '0, cnt: '0, tag: tag};
      exp_q.push_back(e);
   endtask

   // One clock cycle: called at a negedge, drives the DMA-engine model, samples
   // just after, updates the models, and returns at the next negedge.
   task automatic cycle();
      ev_t e;
      bit  ok;
      i_dma_busy = force_busy || (job_left != 0) || (rand_noise && $urandom_range(0, 3) == 0);
      i_dma_done = stray_done || (job_left == 1 && !stall) ||
                   (rand_noise && job_left == 0 && $urandom_range(0, 5) == 0);
      #1;
      accepted = i_cmd_valid && o_cmd_ready;
      if (accepted) begin
         add_desc(i_cmd_dir, i_cmd_ddr_addr, i_cmd_sram_addr, i_cmd_bytes, i_cmd_tag);
         push_cyc = cyc;
      end
      if (i_dma_done && job_left == 1) begin
         check("hold_count", o_dma_byte_count, cur_cnt);
         job_left = 0;
         done_cyc = cyc;
      end else if (job_left > 1 && !stall) begin
         job_left--;
      end
      if (o_dma_start) begin
         n_start++;
         start_cyc = cyc;
         check("start_while_busy", i_dma_busy, 1'b0);
         ok = (exp_q.size() != 0) && !exp_q[0].is_cpl;
         check("start_expected", ok, 1'b1);
         if (ok) begin
            e = exp_q.pop_front();
            check("dma_dir", o_dma_direction, e.dir);
            check("dma_ddr", o_dma_ddr_addr, e.ddr);
            check("dma_sram", o_dma_sram_addr, e.sram);
            check("dma_count", o_dma_byte_count, e.cnt);
            cur_cnt = e.cnt;
         end
         job_left = $urandom_range(1, 4);
      end
      if (o_cpl_valid) begin
         n_cpl++;
         cpl_cyc = cyc;
         ok = (exp_q.size() != 0) && exp_q[0].is_cpl;
         check("cpl_expected", ok, 1'b1);
         if (ok) begin
            e = exp_q.pop_front();
            check("cpl_tag", o_cpl_tag, e.tag);
         end
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic push_desc(input bit dir, input logic [31:0] ddr, input logic [15:0] sram,
                            input logic [31:0] bytes, input logic [3:0] tag);
      int n;
      n = 0;
      i_cmd_valid     = 1'b1;
      i_cmd_dir       = dir;
      i_cmd_ddr_addr  = ddr;
      i_cmd_sram_addr = sram;
      i_cmd_bytes     = bytes;
      i_cmd_tag       = tag;
      do begin
         cycle();
         n++;
      end while (!accepted && n < 500);
      i_cmd_valid = 1'b0;
      check("push_accepted", accepted, 1'b1);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !o_idle) && n < budget) begin
         cycle();
         n++;
      end
      check("drained", {o_idle, exp_q.size() == 0}, 2'b11);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s0;
      int c0;
      int seen;
      int acc;

      // Reset values
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_ready", o_cmd_ready, 1'b1);
      check("rst_idle", o_idle, 1'b1);
      check("rst_start", o_dma_start, 1'b0);
      check("rst_cpl", o_cpl_valid, 1'b0);
      check("rst_level", o_queue_level, 3'd0);
      check("rst_dma_fields", {o_dma_direction, o_dma_ddr_addr, o_dma_sram_addr, o_dma_byte_count}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) cycle();

      // Single descriptor, pop-to-start and done-to-completion latency
      s0 = n_start;
      c0 = n_cpl;
      push_desc(1'b0, 32'h1000, 16'h0040, 32'd128, 4'd3);
      drain(100);
      check("t1_jobs", n_start - s0, 1);
      check("t1_cpls", n_cpl - c0, 1);
      check("t1_push_to_start", start_cyc - push_cyc, 3);
      check("t1_done_to_cpl", cpl_cyc - done_cyc, 1);

      // Chunking into 4096/4096/1808
      s0 = n_start;
      c0 = n_cpl;
      seen = n_start;
      push_desc(1'b1, 32'h0, 16'h0, 32'd10000, 4'd5);
      for (int i = 0; i < 300 && n_cpl == c0; i++) begin
         cycle();
         if (n_start != seen) begin
            seen = n_start;
            if (n_start - s0 > 1) check("t2_done_to_start", start_cyc - done_cyc, 2);
         end
      end
      drain(50);
      check("t2_jobs", n_start - s0, 3);
      check("t2_cpls", n_cpl - c0, 1);

      // FIFO full while the DMA engine is stalled
      stall = 1'b1;
      s0 = n_start;
      push_desc(1'b0, 32'h4000, 16'h0100, 32'd64, 4'd1);
      for (int i = 0; i < 50 && n_start == s0; i++) cycle();
      for (int t = 2; t <= 5; t++) push_desc(t[0], 32'h5000 + 32'(t * 'h100), 16'(t * 16), 32'(t * 8), 4'(t));
      #1;
      check("t3_full_ready", o_cmd_ready, 1'b0);
      check("t3_full_level", o_queue_level, 3'd4);
      acc = 0;
      i_cmd_valid = 1'b1;
      i_cmd_tag   = 4'd9;
      i_cmd_bytes = 32'd16;
      repeat (5) begin
         cycle();
         if (accepted) acc++;
      end
      i_cmd_valid = 1'b0;
      check("t3_no_push_when_full", acc, 0);
      stall = 1'b0;
      drain(400);

      // Zero-length descriptor
      s0 = n_start;
      c0 = n_cpl;
      push_desc(1'b0, 32'h2000, 16'h0080, 32'd0, 4'd7);
      drain(20);
      check("t4_no_job", n_start - s0, 0);
      check("t4_cpls", n_cpl - c0, 1);
      check("t4_push_to_cpl", cpl_cyc - push_cyc, 3);

      // Busy held on ISSUE entry, then a stray done while idle
      force_busy = 1'b1;
      s0 = n_start;
      push_desc(1'b1, 32'h6000, 16'h0200, 32'd256, 4'd6);
      repeat (8) cycle();
      check("t5_no_start_busy", n_start - s0, 0);
      force_busy = 1'b0;
      cycle();
      check("t5_start_on_release", n_start - s0, 1);
      drain(50);
      check("t5_single_start", n_start - s0, 1);
      s0 = n_start;
      c0 = n_cpl;
      stray_done = 1'b1;
      cycle();
      stray_done = 1'b0;
      repeat (4) cycle();
      check("t5_stray_idle", o_idle, 1'b1);
      check("t5_stray_no_activity", (n_start - s0) + (n_cpl - c0), 0);

      // Reset while waiting for dma_done
      stall = 1'b1;
      s0 = n_start;
      push_desc(1'b0, 32'h3000, 16'h0100, 32'd8192, 4'd8);
      push_desc(1'b0, 32'h7000, 16'h0300, 32'd64, 4'd9);
      for (int i = 0; i < 50 && n_start == s0; i++) cycle();
      cycle();
      rst_n = 1'b0;
      #1;
      check("t6_ready", o_cmd_ready, 1'b1);
      check("t6_idle", o_idle, 1'b1);
      check("t6_start", o_dma_start, 1'b0);
      check("t6_level", o_queue_level, 3'd0);
      exp_q.delete();
      job_left = 0;
      stall    = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      c0 = n_cpl;
      repeat (20) cycle();
      check("t6_no_cpl_after_reset", n_cpl - c0, 0);
      check("t6_idle_after", o_idle, 1'b1);

      // Randomized traffic with busy/done noise
      rand_noise = 1'b1;
      for (int d = 0; d < 60; d++) begin
         logic [31:0] bytes;
         logic [31:0] ddr;
         case ($urandom_range(0, 4))
            0:       bytes = 32'd0;
            1:       bytes = 32'(8 * $urandom_range(1, 64));
            2:       bytes = 32'($urandom_range(1, 12000));
            3:       bytes = ($urandom_range(0, 1) != 0) ? 32'd4096 : 32'd8192;
            default: bytes = 32'($urandom_range(4095, 4097));
         endcase
         ddr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_F000 + 32'($urandom_range(0, 255) * 8)) : $urandom;
         repeat ($urandom_range(0, 3)) cycle();
         push_desc(1'($urandom_range(0, 1)), ddr, 16'($urandom), bytes, 4'($urandom_range(0, 15)));
      end
      drain(5000);
      rand_noise = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
